// File: rtl/io_filter.sv
// io_filter: per-pin input conditioning and output latch.
// Each pin passes through a two-flop synchroniser and a saturating debounce
// counter before its value reaches the MCU. Edge pulses come from comparing
// the stable value with its one-cycle-delayed copy. Output pins read back
// their own latch value instead of the pad.
// Interface note: there is no valid/ready handshake. Every input is sampled
// on every rising edge of clk, and every output is a registered level or a
// one-cycle pulse.
module io_filter #(
    parameter int IO_PINS        = 16,
    parameter int DEB_W          = 4,
    parameter int DEFAULT_THRESH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IO_PINS-1:0] pin_dir,
    input  logic [IO_PINS-1:0] pin_data_in,
    output logic [IO_PINS-1:0] pin_data_out,
    input  logic [IO_PINS-1:0] mcu_out,
    input  logic [IO_PINS-1:0] mcu_we,
    output logic [IO_PINS-1:0] mcu_in,
    output logic [IO_PINS-1:0] mcu_rise,
    output logic [IO_PINS-1:0] mcu_fall,
    input  logic               cfg_we,
    input  logic [DEB_W-1:0]   cfg_wdata
);

    logic [IO_PINS-1:0] s1, s2, st, pst, out;
    logic [IO_PINS-1:0] st_nxt;
    logic [DEB_W-1:0]   cnt     [IO_PINS];
    logic [DEB_W-1:0]   cnt_nxt [IO_PINS];
    logic [DEB_W-1:0]   thr;

    // Debounce decision per pin: output pins mirror the latch, input pins
    // accept s2 once it has disagreed with st for more than thr cycles.
    always_comb begin
        st_nxt = st;
        for (int i = 0; i < IO_PINS; i++) begin
            cnt_nxt[i] = '0;
            if (pin_dir[i]) begin
                st_nxt[i]  = out[i];
                cnt_nxt[i] = '0;
            end else if (s2[i] == st[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] >= thr) begin
                st_nxt[i]  = s2[i];
                cnt_nxt[i] = '0;
            end else begin
                cnt_nxt[i] = cnt[i] + 1'b1;
            end
        end
    end

    // Synchroniser, stable/previous values and output latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= '0;
            s2  <= '0;
            st  <= '0;
            pst <= '0;
            out <= '0;
        end else begin
            s1  <= pin_data_in;
            s2  <= s1;
            st  <= st_nxt;
            pst <= st;
            out <= (out & ~mcu_we) | (mcu_out & mcu_we);
        end
    end

    // Per-pin debounce counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IO_PINS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < IO_PINS; i++) cnt[i] <= cnt_nxt[i];
        end
    end

    // Shared debounce threshold; a write takes effect from the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr <= DEB_W'(DEFAULT_THRESH);
        end else if (cfg_we) begin
            thr <= cfg_wdata;
        end
    end

    // Edge pulses come straight from registers, so they are glitch-free.
    always_comb begin
        mcu_in       = st;
        pin_data_out = out;
        mcu_rise     = st & ~pst;
        mcu_fall     = ~st & pst;
    end

endmodule

// File: tb/tb_io_filter.sv
// Testbench for io_filter: directed scenarios followed by random toggling,
// with a cycle-level reference model feeding an expected-value queue.
module tb_io_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pin_dir, pin_data_in, pin_data_out;
    logic [15:0] mcu_out, mcu_we, mcu_in, mcu_rise, mcu_fall;
    logic        cfg_we;
    logic [3:0]  cfg_wdata;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [15:0] m_s1, m_s2, m_st, m_pst, m_out;
    logic [3:0]  m_cnt [16];
    logic [3:0]  m_thr;

    // Expected {pin_data_out, mcu_in, mcu_rise, mcu_fall} after each edge.
    logic [63:0] exp_q[$];

    io_filter #(.IO_PINS(16), .DEB_W(4), .DEFAULT_THRESH(3)) dut (
        .clk(clk), .rst(rst), .pin_dir(pin_dir), .pin_data_in(pin_data_in),
        .pin_data_out(pin_data_out), .mcu_out(mcu_out), .mcu_we(mcu_we),
        .mcu_in(mcu_in), .mcu_rise(mcu_rise), .mcu_fall(mcu_fall),
        .cfg_we(cfg_we), .cfg_wdata(cfg_wdata)
    );

    // Clock block.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_st = '0; m_pst = '0; m_out = '0;
        for (int i = 0; i < 16; i++) m_cnt[i] = '0;
        m_thr = 4'd3;
    endtask

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_step();
        logic [15:0] n_st;
        n_st = m_st;
        for (int i = 0; i < 16; i++) begin
            if (pin_dir[i]) begin
                n_st[i] = m_out[i];
                m_cnt[i] = '0;
            end else if (m_s2[i] == m_st[i]) begin
                m_cnt[i] = '0;
            end else if (m_cnt[i] >= m_thr) begin
                n_st[i] = m_s2[i];
                m_cnt[i] = '0;
            end else begin
                m_cnt[i] = m_cnt[i] + 4'd1;
            end
        end
        m_pst = m_st;
        m_st  = n_st;
        m_s2  = m_s1;
        m_s1  = pin_data_in;
        m_out = (m_out & ~mcu_we) | (mcu_out & mcu_we);
        if (cfg_we) m_thr = cfg_wdata;
    endtask

    // Driver: push expectation, take one edge, pop and compare.
    task automatic tick();
        logic [63:0] e;
        model_step();
        exp_q.push_back({m_out, m_st, m_st & ~m_pst, ~m_st & m_pst});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty observed=0 expected=1");
        end else begin
            e = exp_q.pop_front();
            chk("sb_pdo",  pin_data_out, e[63:48]);
            chk("sb_in",   mcu_in,       e[47:32]);
            chk("sb_rise", mcu_rise,     e[31:16]);
            chk("sb_fall", mcu_fall,     e[15:0]);
            chk("excl",    mcu_rise & mcu_fall, 16'h0000);
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst = 1'b1; pin_dir = '0; pin_data_in = '0; mcu_out = '0; mcu_we = '0;
        cfg_we = 1'b0; cfg_wdata = '0;
        model_reset();
        @(posedge clk); #1;
        chk("por_in",  mcu_in,       16'h0000);
        chk("por_pdo", pin_data_out, 16'h0000);
        rst = 1'b0;

        // Reset: settle all pins high, then assert reset mid-cycle.
        pin_data_in = 16'hFFFF;
        ticks(8);
        chk("pre_rst_in", mcu_in, 16'hFFFF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_in",   mcu_in,       16'h0000);
        chk("rst_pdo",  pin_data_out, 16'h0000);
        chk("rst_rise", mcu_rise,     16'h0000);
        chk("rst_fall", mcu_fall,     16'h0000);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        ticks(5);
        chk("rel_in_e4", mcu_in, 16'h0000);
        tick();
        chk("rel_in_e5",   mcu_in,   16'hFFFF);
        chk("rel_rise_e5", mcu_rise, 16'hFFFF);
        tick();
        chk("rel_rise_e6", mcu_rise, 16'h0000);

        // Glitch rejection on pin 0 with thr = 3.
        pin_data_in = 16'h0000;
        ticks(8);
        chk("gl_base", mcu_in, 16'h0000);
        pin_data_in[0] = 1'b1;
        ticks(3);
        pin_data_in[0] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("gl_short_in",   {15'd0, mcu_in[0]},   16'h0000);
            chk("gl_short_rise", {15'd0, mcu_rise[0]}, 16'h0000);
        end
        pin_data_in[0] = 1'b1;
        ticks(4);
        pin_data_in[0] = 1'b0;
        tick();
        chk("gl_long_e4", {15'd0, mcu_in[0]}, 16'h0000);
        tick();
        chk("gl_long_e5",   {15'd0, mcu_in[0]},   16'h0001);
        chk("gl_long_rise", {15'd0, mcu_rise[0]}, 16'h0001);
        ticks(8);

        // Threshold 0: pin 5 step reaches mcu_in two edges after capture.
        cfg_we = 1'b1; cfg_wdata = 4'd0;
        tick();
        cfg_we = 1'b0;
        pin_data_in[5] = 1'b1;
        ticks(2);
        chk("t0_e1", {15'd0, mcu_in[5]}, 16'h0000);
        tick();
        chk("t0_e2", {15'd0, mcu_in[5]}, 16'h0001);

        // Threshold 15, then lowered to 2 while the count sits at 7.
        cfg_we = 1'b1; cfg_wdata = 4'd15;
        tick();
        cfg_we = 1'b0;
        pin_data_in[5] = 1'b0;
        ticks(9);
        chk("t15_hold", {15'd0, mcu_in[5]}, 16'h0001);
        cfg_we = 1'b1; cfg_wdata = 4'd2;
        tick();
        cfg_we = 1'b0;
        chk("tlow_same", {15'd0, mcu_in[5]}, 16'h0001);
        tick();
        chk("tlow_next", {15'd0, mcu_in[5]},   16'h0000);
        chk("tlow_fall", {15'd0, mcu_fall[5]}, 16'h0001);
        ticks(4);

        // Output path.
        pin_dir = 16'h00F0; mcu_we = 16'h0010; mcu_out = 16'hFFFF;
        tick();
        mcu_we = 16'h0000;
        chk("op_pdo", pin_data_out, 16'h0010);
        chk("op_in4_early", {15'd0, mcu_in[4]}, 16'h0000);
        tick();
        chk("op_in4",   {15'd0, mcu_in[4]},   16'h0001);
        chk("op_rise4", {15'd0, mcu_rise[4]}, 16'h0001);
        chk("op_in5",   {15'd0, mcu_in[5]},   16'h0000);
        ticks(2);

        // Direction flip on pin 2, thr = 3, pad held low.
        pin_dir = 16'h0004; mcu_we = 16'h0004; mcu_out = 16'hFFFF;
        cfg_we = 1'b1; cfg_wdata = 4'd3;
        tick();
        mcu_we = '0; cfg_we = 1'b0;
        ticks(6);
        chk("df_pre", {15'd0, mcu_in[2]}, 16'h0001);
        pin_dir = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("df_hold", {15'd0, mcu_in[2]}, 16'h0001);
        end
        tick();
        chk("df_in",   {15'd0, mcu_in[2]},   16'h0000);
        chk("df_fall", {15'd0, mcu_fall[2]}, 16'h0001);

        // Random toggling against the model.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0)
                pin_data_in = pin_data_in ^ 16'($urandom & $urandom);
            if ($urandom_range(0, 15) == 0) pin_dir = 16'($urandom & $urandom);
            mcu_we  = 16'($urandom & $urandom);
            mcu_out = 16'($urandom);
            cfg_we  = ($urandom_range(0, 31) == 0);
            cfg_wdata = 4'($urandom_range(0, 4));
            tick();
        end
        cfg_we = 1'b0; mcu_we = '0;
        ticks(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
